// File: rtl/orbit_word_arbiter.sv
// Round-robin arbiter that shares one pipelined word-buffer read port among the frame formers.
// Each requester holds one pending read. Returned words are routed back by a tag pipe.
module orbit_word_arbiter #(
  parameter int N_REQ  = 5,
  parameter int AW     = 11,
  parameter int DW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_pulse,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic                mem_rd,
  output logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_data,
  output logic [N_REQ*DW-1:0] word_out,
  output logic [N_REQ-1:0]    word_valid,
  output logic [N_REQ-1:0]    overrun,
  input  logic                overrun_clr,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  pending_r;
  logic [AW-1:0]     addr_q_r [N_REQ];
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     rd_tag_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [PW-1:0]     pipe_tag_r [RD_LAT];
  logic              grant_vld_s;
  logic [PW-1:0]     grant_idx_s;
  logic [N_REQ-1:0]  grant_mask_s;
  logic [N_REQ-1:0]  ov_set_s;

  // Circular index: wraps at N_REQ, not at the next power of two.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return PW'(sum);
  endfunction

  // First pending requester at or after ptr; scanning backwards lets the nearest one win.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending_r[wrap_idx(ptr_r, k)]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = wrap_idx(ptr_r, k);
      end else begin
      end
    end
  end

  // One-hot view of this cycle's grant.
  always_comb begin
    grant_mask_s = '0;
    if (grant_vld_s) begin
      grant_mask_s[grant_idx_s] = 1'b1;
    end else begin
      grant_mask_s = '0;
    end
  end

  // A pulse on a requester that is pending and not being granted drops its older request.
  assign ov_set_s = req_pulse & pending_r & ~grant_mask_s;

  // Request capture, grant issue, tag pipe and word return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= '0;
      ptr_r      <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      rd_tag_r   <= '0;
      pipe_vld_r <= '0;
      word_out   <= '0;
      word_valid <= '0;
      overrun    <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        addr_q_r[i] <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_tag_r[i] <= '0;
      end
    end else begin
      mem_rd <= grant_vld_s;
      if (grant_vld_s) begin
        mem_addr <= addr_q_r[grant_idx_s];
        rd_tag_r <= grant_idx_s;
        ptr_r    <= (grant_idx_s == PW'(N_REQ - 1)) ? '0 : grant_idx_s + PW'(1);
      end else begin
        ptr_r <= ptr_r;
      end

      pipe_vld_r[0] <= mem_rd;
      pipe_tag_r[0] <= rd_tag_r;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end

      word_valid <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (pipe_vld_r[RD_LAT-1] && (pipe_tag_r[RD_LAT-1] == PW'(i))) begin
          word_valid[i]          <= 1'b1;
          word_out[i*DW +: DW]   <= mem_data;
        end else begin
          word_valid[i] <= 1'b0;
        end
      end

      // A new pulse re-arms pending even when the same requester is granted this cycle.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_pulse[i]) begin
          pending_r[i] <= 1'b1;
          addr_q_r[i]  <= req_addr[i*AW +: AW];
        end else if (grant_mask_s[i]) begin
          pending_r[i] <= 1'b0;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end

      overrun <= overrun_clr ? ov_set_s : (overrun | ov_set_s);
      busy    <= (|pending_r) | mem_rd | (|pipe_vld_r);
    end
  end

endmodule
